// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and helpers for the register scoreboard.
// Error causes are reserved for a future cause output.
package reg_scoreboard_pkg;

  localparam int REG_SB_CNT_W = 2;

  typedef enum logic [1:0] {
    SB_ERR_NONE  = 2'd0,
    SB_ERR_OVF   = 2'd1,
    SB_ERR_UNF   = 2'd2,
    SB_ERR_MULTI = 2'd3
  } sb_err_e;

  function automatic logic [1:0] sb_dec(
    input logic a,
    input logic b,
    input logic c
  );
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/reg_scoreboard_cell.sv
// One saturating in-flight writer counter for a single register.
// Net change is formed signed, then clamped to 0..max.
module reg_scoreboard_cell #(
  parameter int CNT_W = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output logic       nz_o,
  output logic       sat_o,
  output logic       err_o
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_nxt;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_max;
  logic                 w_ovf;
  logic                 w_unf;

  assign w_max = $signed({2'b00, MAX});
  assign w_sum = $signed({2'b00, r_cnt})
               + $signed({{(CNT_W+1){1'b0}}, inc_i})
               - $signed({{CNT_W{1'b0}}, dec_i});

  assign w_unf = w_sum[SW-1];
  assign w_ovf = w_sum > w_max;

  always_comb begin
    w_nxt = w_sum[CNT_W-1:0];
    if (w_unf) begin
      w_nxt = '0;
    end else if (w_ovf) begin
      w_nxt = MAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign nz_o  = |r_cnt;
  assign sat_o = &r_cnt;
  assign err_o = w_ovf | w_unf;

endmodule

// File: rtl/reg_scoreboard.sv
// In-flight destination register scoreboard for x1..x31.
// Outputs decode straight from counter state; error flag is sticky.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = REG_SB_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_i,
  input  logic [31:1] issue_onehot_i,
  input  logic        retire_i,
  input  logic [4:0]  retire_reg_i,
  input  logic        kill0_i,
  input  logic [4:0]  kill0_reg_i,
  input  logic        kill1_i,
  input  logic [4:0]  kill1_reg_i,
  output logic [31:1] wb_reg_onfly_o,
  output logic [31:1] wb_reg_sat_o,
  output logic        busy_o,
  output logic        err_o
);

  logic [31:1] w_cell_err;
  logic        w_multi;
  logic        r_err;

  assign w_multi = issue_i &&
    ((issue_onehot_i & (issue_onehot_i - 31'd1)) != '0);

  for (genvar r = 1; r < 32; r++) begin : g_cell
    logic       w_ret;
    logic       w_k0;
    logic       w_k1;
    logic [1:0] w_dec;

    assign w_ret = retire_i && (retire_reg_i == 5'(r));
    assign w_k0  = kill0_i && (kill0_reg_i == 5'(r));
    assign w_k1  = kill1_i && (kill1_reg_i == 5'(r));
    assign w_dec = sb_dec(w_ret, w_k0, w_k1);

    reg_scoreboard_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (issue_i & issue_onehot_i[r]),
      .dec_i (w_dec),
      .nz_o  (wb_reg_onfly_o[r]),
      .sat_o (wb_reg_sat_o[r]),
      .err_o (w_cell_err[r])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_multi | (|w_cell_err);
    end
  end

  assign busy_o = |wb_reg_onfly_o;
  assign err_o  = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: stimulus pushes predicted outputs, monitor pops
// and compares them after each rising edge.
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_i = 1'b0;
  logic [31:1] issue_onehot_i = '0;
  logic        retire_i = 1'b0;
  logic [4:0]  retire_reg_i = '0;
  logic        kill0_i = 1'b0;
  logic [4:0]  kill0_reg_i = '0;
  logic        kill1_i = 1'b0;
  logic [4:0]  kill1_reg_i = '0;
  logic [31:1] wb_reg_onfly_o;
  logic [31:1] wb_reg_sat_o;
  logic        busy_o;
  logic        err_o;

  reg_scoreboard dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .issue_i       (issue_i),
    .issue_onehot_i(issue_onehot_i),
    .retire_i      (retire_i),
    .retire_reg_i  (retire_reg_i),
    .kill0_i       (kill0_i),
    .kill0_reg_i   (kill0_reg_i),
    .kill1_i       (kill1_i),
    .kill1_reg_i   (kill1_reg_i),
    .wb_reg_onfly_o(wb_reg_onfly_o),
    .wb_reg_sat_o  (wb_reg_sat_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:1] onfly;
    logic [31:1] sat;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   cnt[32];
  bit   merr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("onfly", e.tag, {1'b0, wb_reg_onfly_o}, {1'b0, e.onfly});
      check("sat", e.tag, {1'b0, wb_reg_sat_o}, {1'b0, e.sat});
      check("busy", e.tag, {31'b0, busy_o}, {31'b0, e.busy});
      check("err", e.tag, {31'b0, err_o}, {31'b0, e.err});
    end
  end

  // Drive one cycle of inputs and predict the state after the next edge.
  task automatic step(input bit rst, input bit iss, input logic [31:1] oh,
                      input bit ret, input int rr,
                      input bit k0, input int k0r,
                      input bit k1, input int k1r);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni = ~rst;
    issue_i = iss;
    issue_onehot_i = oh;
    retire_i = ret;
    retire_reg_i = 5'(rr);
    kill0_i = k0;
    kill0_reg_i = 5'(k0r);
    kill1_i = k1;
    kill1_reg_i = 5'(k1r);
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] = 0;
      merr = 1'b0;
    end else begin
      if (iss && $countones(oh) > 1) merr = 1'b1;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = cnt[r];
        if (iss && oh[r]) n = n + 1;
        if (ret && rr == r) n = n - 1;
        if (k0 && k0r == r) n = n - 1;
        if (k1 && k1r == r) n = n - 1;
        if (n > MAXC) begin
          n = MAXC;
          merr = 1'b1;
        end
        if (n < 0) begin
          n = 0;
          merr = 1'b1;
        end
        cnt[r] = n;
      end
    end
    e.tag = cyc + 1;
    e.busy = 1'b0;
    for (int r = 1; r < 32; r++) begin
      e.onfly[r] = cnt[r] != 0;
      e.sat[r] = cnt[r] == MAXC;
      if (cnt[r] != 0) e.busy = 1'b1;
    end
    e.err = merr;
    q.push_back(e);
  endtask

  function automatic logic [31:1] ohf(input int r);
    logic [31:1] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    step(1, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    rst_cyc();
    idle();
    // single issue/retire of x5
    step(0, 1, ohf(5), 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    step(0, 0, '0, 1, 5, 0, 0, 0, 0);
    idle();
    // saturate x7 then overflow
    rst_cyc();
    repeat (3) step(0, 1, ohf(7), 0, 0, 0, 0, 0, 0);
    step(0, 1, ohf(7), 0, 0, 0, 0, 0, 0);
    idle();
    // issue+retire same reg at count 1, then at count 0
    rst_cyc();
    step(0, 1, ohf(9), 0, 0, 0, 0, 0, 0);
    step(0, 1, ohf(9), 1, 9, 0, 0, 0, 0);
    step(0, 0, '0, 1, 9, 0, 0, 0, 0);
    step(0, 1, ohf(9), 1, 9, 0, 0, 0, 0);
    idle();
    // double kill then underflow
    rst_cyc();
    step(0, 1, ohf(3), 0, 0, 0, 0, 0, 0);
    step(0, 1, ohf(3), 0, 0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1, 3, 1, 3);
    step(0, 0, '0, 1, 3, 0, 0, 0, 0);
    idle();
    // x0 events ignored, empty issue legal, then multi-bit issue
    rst_cyc();
    step(0, 1, ohf(4), 0, 0, 0, 0, 0, 0);
    step(0, 1, '0, 1, 0, 1, 0, 1, 0);
    idle();
    step(0, 1, ohf(2) | ohf(30), 0, 0, 0, 0, 0, 0);
    step(1, 1, ohf(4), 0, 0, 0, 0, 0, 0);
    idle();
    // randomized traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      bit iss;
      logic [31:1] oh;
      int rr, k0r, k1r;
      iss = $urandom_range(0, 1);
      oh = ($urandom_range(0, 7) == 0) ? '0 : ohf($urandom_range(1, 31));
      if ($urandom_range(0, 40) == 0) oh = oh | ohf($urandom_range(1, 31));
      rr = $urandom_range(0, 31);
      k0r = $urandom_range(0, 31);
      k1r = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0) rr = rr % 4;
      if ($urandom_range(0, 3) != 0) k0r = k0r % 4;
      step($urandom_range(0, 150) == 0, iss, oh,
           $urandom_range(0, 2) == 0, rr,
           $urandom_range(0, 5) == 0, k0r,
           $urandom_range(0, 9) == 0, k1r);
    end
    idle();
    repeat (10) begin
      if (q.size() > 0) @(negedge clk);
    end
    #1;
    if (q.size() > 0) begin
      nfail++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
